stopwatch_lap_core: RTL and testbench

Parametrised stopwatch/countdown core that replaces the fixed-function stopwatch under the Tiny Tapeout wrapper. It keeps an MM:SS time in BCD, counts up or down from a 1 Hz tick derived from `clk`, supports lap freeze and preset increments, and drives a 4-digit multiplexed 7-segment display. Buttons arrive already synchronised; the block edge-detects them internally.

---
 rtl/stopwatch_lap_core.sv | 207 ++++++++++++++++++++
 tb/tb_stopwatch_lap_core.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core: MM:SS BCD stopwatch / countdown with a lap freeze,
// preset buttons and a 4-digit multiplexed active-low 7-segment display.
module stopwatch_lap_core #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_DIV = 50_000,
  parameter int MIN_MAX  = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       lap_btn,
  input  logic       clear_btn,
  input  logic       inc_min_btn,
  input  logic       inc_sec_btn,
  input  logic       down_sw,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       running,
  output logic       expired,
  output logic       lap_active
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] MAX_T = 4'(MIN_MAX / 10);
  localparam logic [3:0] MAX_O = 4'(MIN_MAX % 10);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_EXP = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [5:0]    btn_now, btn_q, btn_e;
  logic          start_e, stop_e, lap_e, clear_e, inc_min_e, inc_sec_e;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   time_q, time_d, latch_q, latch_d;   // {m_tens, m_ones, s_tens, s_ones}
  logic          lap_q, lap_d;
  logic [3:0]    s1, s10, m1, m10;
  logic [7:0]    sec_inc, sec_dec, min_inc, min_dec;
  logic          sec_carry, sec_borrow;
  logic [15:0]   up_time, dn_time;
  logic          tick, expire, time_zero;
  logic [SW-1:0] scan_q;
  logic [1:0]    dig_q;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic [15:0]   disp_time;
  logic [3:0]    disp_bcd;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: seg_code = 7'b1000000;
      4'd1: seg_code = 7'b1111001;
      4'd2: seg_code = 7'b0100100;
      4'd3: seg_code = 7'b0110000;
      4'd4: seg_code = 7'b0011001;
      4'd5: seg_code = 7'b0010010;
      4'd6: seg_code = 7'b0000010;
      4'd7: seg_code = 7'b1111000;
      4'd8: seg_code = 7'b0000000;
      4'd9: seg_code = 7'b0010000;
      default: seg_code = 7'b1111111;
    endcase
  endfunction

  assign btn_now   = {inc_sec_btn, inc_min_btn, clear_btn, lap_btn, stop_btn, start_btn};
  assign btn_e     = btn_now & ~btn_q;
  assign start_e   = btn_e[0];
  assign stop_e    = btn_e[1];
  assign lap_e     = btn_e[2];
  assign clear_e   = btn_e[3];
  assign inc_min_e = btn_e[4];
  assign inc_sec_e = btn_e[5];

  assign {m10, m1, s10, s1} = time_q;
  assign time_zero = (time_q == 16'h0000);
  assign tick      = (state_q == S_RUN) && (presc_q == PW'(CLK_HZ - 1));
  // A stop on the tick cycle wins: the second is abandoned, not counted.
  assign expire    = tick && !stop_e && down_sw && (dn_time == 16'h0000);

  // Previous button levels; reset high so a button held through reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= '1;
    else     btn_q <= btn_now;
  end

  // BCD +1 / -1 candidates for seconds and minutes, shared by ticks and presets.
  always_comb begin
    sec_carry  = 1'b0;
    sec_borrow = 1'b0;
    if (s1 == 4'd9) begin
      if (s10 == 4'd5) begin sec_inc = 8'h00; sec_carry = 1'b1; end
      else             sec_inc = {s10 + 4'd1, 4'd0};
    end else           sec_inc = {s10, s1 + 4'd1};
    if (s1 == 4'd0) begin
      if (s10 == 4'd0) begin sec_dec = 8'h59; sec_borrow = 1'b1; end
      else             sec_dec = {s10 - 4'd1, 4'd9};
    end else           sec_dec = {s10, s1 - 4'd1};
    if ({m10, m1} == {MAX_T, MAX_O}) min_inc = 8'h00;
    else if (m1 == 4'd9)             min_inc = {m10 + 4'd1, 4'd0};
    else                             min_inc = {m10, m1 + 4'd1};
    if ({m10, m1} == 8'h00)          min_dec = {MAX_T, MAX_O};
    else if (m1 == 4'd0)             min_dec = {m10 - 4'd1, 4'd9};
    else                             min_dec = {m10, m1 - 4'd1};
    up_time = {sec_carry  ? min_inc : {m10, m1}, sec_inc};
    dn_time = {sec_borrow ? min_dec : {m10, m1}, sec_dec};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: clear beats stop, stop beats start.
  always_comb begin
    state_d = state_q;
    if (clear_e) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (start_e && !stop_e && !(down_sw && time_zero)) state_d = S_RUN;
        S_RUN:   if (stop_e) state_d = S_IDLE;
                 else if (expire) state_d = S_EXP;
        S_EXP:   if (inc_min_e || inc_sec_e) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    running    = (state_q == S_RUN);
    expired    = (state_q == S_EXP);
    lap_active = lap_q;
  end

  // Time, prescaler and lap next-state.
  always_comb begin
    time_d  = time_q;
    latch_d = latch_q;
    lap_d   = lap_q;
    presc_d = '0;
    if (clear_e) begin
      time_d = '0;
      lap_d  = 1'b0;
    end else if (state_q == S_RUN) begin
      if (!stop_e) begin
        if (tick) time_d  = down_sw ? dn_time : up_time;
        else      presc_d = presc_q + PW'(1);
      end
      if (lap_e) begin
        lap_d = ~lap_q;
        if (!lap_q) latch_d = time_q;
      end
      if (expire) lap_d = 1'b0;
    end else begin
      if (inc_sec_e) time_d[7:0]  = sec_inc;
      if (inc_min_e) time_d[15:8] = min_inc;
      if (lap_e && state_q == S_IDLE) lap_d = 1'b0;
    end
  end

  // Time, lap latch and prescaler registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q  <= '0;
      latch_q <= '0;
      lap_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      time_q  <= time_d;
      latch_q <= latch_d;
      lap_q   <= lap_d;
      presc_q <= presc_d;
    end
  end

  // Digit selection and segment encoding for the digit currently scanned.
  always_comb begin
    disp_time = lap_q ? latch_q : time_q;
    disp_bcd  = disp_time[{dig_q, 2'b00} +: 4];
    seg_d     = seg_code(disp_bcd);
    an_d      = ~(4'b0001 << dig_q);
  end

  // Scan counter, digit index and registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q <= '0;
      dig_q  <= 2'd0;
      seg_q  <= 7'b1111111;
      an_q   <= 4'b1111;
    end else begin
      if (scan_q == SW'(SCAN_DIV - 1)) begin
        scan_q <= '0;
        dig_q  <= dig_q + 2'd1;
      end else begin
        scan_q <= scan_q + SW'(1);
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core with CLK_HZ=10, SCAN_DIV=4, MIN_MAX=2.
module tb_stopwatch_lap_core;

  localparam int B_START = 0, B_STOP = 1, B_LAP = 2, B_CLEAR = 3, B_INCM = 4, B_INCS = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] btns = '0;
  logic       down_sw = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       running, expired, lap_active;
  logic [15:0] disp;
  int checks = 0;
  int errors = 0;

  stopwatch_lap_core #(.CLK_HZ(10), .SCAN_DIV(4), .MIN_MAX(2)) dut (
    .clk(clk), .rst(rst),
    .start_btn(btns[B_START]), .stop_btn(btns[B_STOP]), .lap_btn(btns[B_LAP]),
    .clear_btn(btns[B_CLEAR]), .inc_min_btn(btns[B_INCM]), .inc_sec_btn(btns[B_INCS]),
    .down_sw(down_sw), .seg(seg), .an(an),
    .running(running), .expired(expired), .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    btns[idx] = 1'b1; cycle(1);
    btns[idx] = 1'b0; cycle(1);
  endtask

  function automatic logic [3:0] dec7(input logic [6:0] s);
    case (s)
      7'b1000000: dec7 = 4'd0;
      7'b1111001: dec7 = 4'd1;
      7'b0100100: dec7 = 4'd2;
      7'b0110000: dec7 = 4'd3;
      7'b0011001: dec7 = 4'd4;
      7'b0010010: dec7 = 4'd5;
      7'b0000010: dec7 = 4'd6;
      7'b1111000: dec7 = 4'd7;
      7'b0000000: dec7 = 4'd8;
      7'b0010000: dec7 = 4'd9;
      default:    dec7 = 4'hF;
    endcase
  endfunction

  // Exactly one full scan (16 cycles); any digit not seen stays F.
  task automatic read_disp(output logic [15:0] val);
    val = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      cycle(1);
      case (an)
        4'b1110: val[3:0]   = dec7(seg);
        4'b1101: val[7:4]   = dec7(seg);
        4'b1011: val[11:8]  = dec7(seg);
        4'b0111: val[15:12] = dec7(seg);
        default: ;
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_seg", {9'd0, seg}, 16'h007F);
    chk("rst_an", {12'd0, an}, 16'h000F);
    chk("rst_flags", {13'd0, running, expired, lap_active}, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cycle(1);
    chk("first_an", {12'd0, an}, 16'h000E);
    chk("first_seg", {9'd0, seg}, 16'h0040);
    cycle(4);
    chk("scan_an1", {12'd0, an}, 16'h000D);
    chk("scan_seg1", {9'd0, seg}, 16'h0040);

    // Count up 30 cycles, stop, read back.
    press(B_START);
    cycle(29);
    chk("up_running", {15'd0, running}, 16'h0001);
    press(B_STOP);
    chk("up_stopped", {15'd0, running}, 16'h0000);
    read_disp(disp);
    chk("up_0003", disp, 16'h0003);

    // Presets: seconds wrap without carry, then 02:59.
    for (int i = 0; i < 56; i++) press(B_INCS);
    read_disp(disp);
    chk("inc_0059", disp, 16'h0059);
    press(B_INCS);
    read_disp(disp);
    chk("inc_sec_wrap", disp, 16'h0000);
    for (int i = 0; i < 59; i++) press(B_INCS);
    press(B_INCM);
    press(B_INCM);
    read_disp(disp);
    chk("preset_0259", disp, 16'h0259);

    // Full wrap MIN_MAX:59 -> 00:00 keeps running.
    press(B_START);
    cycle(9);
    chk("wrap_running", {15'd0, running}, 16'h0001);
    press(B_STOP);
    read_disp(disp);
    chk("wrap_0000", disp, 16'h0000);

    // Countdown to expiry.
    press(B_INCS);
    press(B_INCS);
    down_sw = 1'b1;
    press(B_START);
    cycle(18);
    chk("dn_pre_exp", {14'd0, running, expired}, 16'h0002);
    cycle(1);
    chk("dn_expired", {14'd0, running, expired}, 16'h0001);
    press(B_START);
    chk("exp_start_ign", {14'd0, running, expired}, 16'h0001);
    read_disp(disp);
    chk("exp_disp", disp, 16'h0000);
    press(B_INCS);
    chk("exp_inc_idle", {14'd0, running, expired}, 16'h0000);
    read_disp(disp);
    chk("exp_inc_0001", disp, 16'h0001);

    // Lap freeze while counting continues.
    down_sw = 1'b0;
    press(B_CLEAR);
    press(B_START);
    cycle(20);
    press(B_LAP);
    chk("lap_set", {15'd0, lap_active}, 16'h0001);
    read_disp(disp);
    chk("lap_frozen", disp, 16'h0002);
    cycle(12);
    press(B_LAP);
    chk("lap_clr", {15'd0, lap_active}, 16'h0000);
    press(B_STOP);
    read_disp(disp);
    chk("lap_live_0005", disp, 16'h0005);

    // Start and stop together in IDLE: stop wins.
    btns[B_START] = 1'b1;
    btns[B_STOP]  = 1'b1;
    cycle(1);
    btns[B_START] = 1'b0;
    btns[B_STOP]  = 1'b0;
    cycle(1);
    chk("start_stop", {15'd0, running}, 16'h0000);

    // Clear mid-second during RUN, then the next second is a full one.
    press(B_START);
    cycle(4);
    press(B_CLEAR);
    chk("clear_idle", {15'd0, running}, 16'h0000);
    read_disp(disp);
    chk("clear_0000", disp, 16'h0000);
    press(B_START);
    cycle(7);
    press(B_STOP);
    read_disp(disp);
    chk("tick_not_9", disp, 16'h0000);
    press(B_START);
    cycle(9);
    press(B_STOP);
    read_disp(disp);
    chk("tick_at_10", disp, 16'h0001);

    // Presets ignored while running.
    press(B_START);
    press(B_INCM);
    press(B_INCS);
    press(B_STOP);
    read_disp(disp);
    chk("run_inc_ign", disp, 16'h0001);

    // Minute preset wraps at MIN_MAX.
    press(B_CLEAR);
    press(B_INCM);
    press(B_INCM);
    read_disp(disp);
    chk("incm_0200", disp, 16'h0200);
    press(B_INCM);
    read_disp(disp);
    chk("incm_wrap", disp, 16'h0000);

    // Down start at 00:00 is refused.
    down_sw = 1'b1;
    press(B_START);
    chk("dn_zero_start", {14'd0, running, expired}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
